// File: rtl/next_pc_seq_if.sv
// Control/datapath bundle between the LEGv8 control, ALU and the next-PC sequencer.
// master = control side driving branch controls; slave = sequencer.
interface next_pc_seq_if #(
   parameter int WIDTH = 64
);
   logic             Stall;
   logic             Branch;
   logic             BranchNZ;
   logic             ALUZero;
   logic             Uncondbranch;
   logic             Link;
   logic             BranchReg;
   logic             Return;
   logic [WIDTH-1:0] SignExtImm;
   logic [WIDTH-1:0] RegTarget;
   logic [WIDTH-1:0] CurrentPC;
   logic [WIDTH-1:0] NextPC;
   logic             Taken;
   logic             MisalignErr;
   logic             RasEmpty;
   logic             RasFull;

   modport master (
      output Stall, Branch, BranchNZ, ALUZero, Uncondbranch, Link, BranchReg, Return,
             SignExtImm, RegTarget,
      input  CurrentPC, NextPC, Taken, MisalignErr, RasEmpty, RasFull
   );

   modport slave (
      input  Stall, Branch, BranchNZ, ALUZero, Uncondbranch, Link, BranchReg, Return,
             SignExtImm, RegTarget,
      output CurrentPC, NextPC, Taken, MisalignErr, RasEmpty, RasFull
   );
endinterface

// File: rtl/next_pc_seq.sv
// LEGv8 program-counter sequencer: owns the PC and resolves the next fetch address.
// Define PC_SEQ_RAS_EN to build the return-address stack; otherwise RET acts like BR.
module next_pc_seq #(
   parameter int               WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_PC    = '0,
   parameter int               INSTR_BYTES = 4,
   parameter int               RAS_DEPTH   = 4
) (
   input logic           CLK,
   input logic           Reset,
   next_pc_seq_if.slave  bus
);

   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] rel_pc;
   logic [WIDTH-1:0] ret_target;
   logic [WIDTH-1:0] target;
   logic             taken;
   logic             cond_taken;
   logic             ras_empty;
   logic             ras_full;

   assign seq_pc     = pc + WIDTH'(INSTR_BYTES);
   assign rel_pc     = pc + bus.SignExtImm;
   assign cond_taken = bus.Branch & (bus.ALUZero ^ bus.BranchNZ);

`ifdef PC_SEQ_RAS_EN
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ras_ptr;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;
   logic [CNT_W-1:0] ras_cnt;
   logic             push;
   logic             pop;

   assign ras_empty  = (ras_cnt == '0);
   assign ras_full   = (ras_cnt == CNT_W'(RAS_DEPTH));
   assign ptr_inc    = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PTR_W'(1);
   assign ptr_dec    = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - PTR_W'(1);
   assign push       = bus.Link & bus.Uncondbranch & ~bus.Stall;
   assign pop        = bus.Return & ~ras_empty & ~bus.Stall;
   assign ret_target = ras_empty ? bus.RegTarget : ras_mem[ras_ptr];

   // ras_ptr always names the top slot; a push when full wraps onto the oldest entry.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (push && pop) begin
         ras_mem[ras_ptr] <= seq_pc;
      end else if (push) begin
         ras_mem[ptr_inc] <= seq_pc;
         ras_ptr          <= ptr_inc;
         if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (pop) begin
         ras_ptr <= ptr_dec;
         ras_cnt <= ras_cnt - CNT_W'(1);
      end
   end
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   logic unused_link;

   assign unused_link = bus.Link;
   assign ras_empty   = 1'b1;
   assign ras_full    = 1'b0;
   assign ret_target  = bus.RegTarget;
`endif

   always_comb begin
      target = seq_pc;
      taken  = 1'b0;
      if (bus.Return) begin
         target = ret_target;
         taken  = 1'b1;
      end else if (bus.BranchReg) begin
         target = bus.RegTarget;
         taken  = 1'b1;
      end else if (bus.Uncondbranch || cond_taken) begin
         target = rel_pc;
         taken  = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset)           pc <= RESET_PC;
      else if (!bus.Stall) pc <= target & ~LOW_MASK;
   end

   assign bus.CurrentPC   = pc;
   assign bus.NextPC      = target & ~LOW_MASK;
   assign bus.Taken       = taken;
   assign bus.MisalignErr = |(target & LOW_MASK);
   assign bus.RasEmpty    = ras_empty;
   assign bus.RasFull     = ras_full;

endmodule

// File: tb/tb_next_pc_seq.sv
// Directed-vector bench for next_pc_seq; RAS vectors run when PC_SEQ_RAS_EN is defined.
module tb_next_pc_seq;

   localparam int          W   = 64;
   localparam logic [63:0] RPC = 64'h400;

   logic CLK = 1'b0;
   logic Reset;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   next_pc_seq_if #(.WIDTH(W)) bus ();

   next_pc_seq #(
      .WIDTH(W), .RESET_PC(RPC), .INSTR_BYTES(4), .RAS_DEPTH(4)
   ) dut (
      .CLK(CLK), .Reset(Reset), .bus(bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.Stall        = 1'b0;
      bus.Branch       = 1'b0;
      bus.BranchNZ     = 1'b0;
      bus.ALUZero      = 1'b0;
      bus.Uncondbranch = 1'b0;
      bus.Link         = 1'b0;
      bus.BranchReg    = 1'b0;
      bus.Return       = 1'b0;
      bus.SignExtImm   = '0;
      bus.RegTarget    = '0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic jump(input logic [63:0] a);
      idle();
      bus.BranchReg = 1'b1;
      bus.RegTarget = a;
      tick();
      idle();
      chk("jump", bus.CurrentPC, a);
   endtask

   initial begin
      Reset = 1'b1;
      idle();
      tick();
      tick();
      chk("rst_pc", bus.CurrentPC, 64'h400);
      chk("rst_empty", bus.RasEmpty, 1);
      chk("rst_full", bus.RasFull, 0);
      Reset = 1'b0;
      settle();
      chk("rst_taken", bus.Taken, 0);
      chk("rst_next", bus.NextPC, 64'h404);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("seq_pc", bus.CurrentPC, 64'h400 + 64'(4 * i));
      end

      // conditional branches at 0x100
      jump(64'h100);
      bus.Branch = 1'b1; bus.SignExtImm = 64'h40;
      bus.BranchNZ = 1'b0; bus.ALUZero = 1'b1;
      settle();
      chk("cbz_t", bus.NextPC, 64'h140);
      chk("cbz_t_tk", bus.Taken, 1);
      bus.ALUZero = 1'b0;
      settle();
      chk("cbz_nt", bus.NextPC, 64'h104);
      chk("cbz_nt_tk", bus.Taken, 0);
      bus.BranchNZ = 1'b1;
      settle();
      chk("cbnz_t", bus.NextPC, 64'h140);
      tick();
      chk("cbnz_pc", bus.CurrentPC, 64'h140);

      // negative offset and wrap-around
      jump(64'h10);
      bus.Uncondbranch = 1'b1; bus.SignExtImm = -64'sd32;
      settle();
      chk("neg_next", bus.NextPC, 64'hFFFF_FFFF_FFFF_FFF0);
      tick();
      chk("neg_pc", bus.CurrentPC, 64'hFFFF_FFFF_FFFF_FFF0);
      jump(64'hFFFF_FFFF_FFFF_FFFC);
      settle();
      chk("wrap_next", bus.NextPC, 64'h0);
      chk("wrap_tk", bus.Taken, 0);
      tick();
      chk("wrap_pc", bus.CurrentPC, 64'h0);

      // misaligned register target
      bus.BranchReg = 1'b1; bus.RegTarget = 64'h1002;
      settle();
      chk("mis_err", bus.MisalignErr, 1);
      chk("mis_next", bus.NextPC, 64'h1000);
      tick();
      chk("mis_pc", bus.CurrentPC, 64'h1000);
      idle();
      settle();
      chk("mis_clr", bus.MisalignErr, 0);

      // stall holds PC and blocks the BL push
      bus.Stall = 1'b1; bus.Uncondbranch = 1'b1; bus.Link = 1'b1; bus.SignExtImm = 64'h80;
      settle();
      chk("stl_next", bus.NextPC, 64'h1080);
      chk("stl_tk", bus.Taken, 1);
      tick();
      chk("stl_pc1", bus.CurrentPC, 64'h1000);
      tick();
      chk("stl_pc2", bus.CurrentPC, 64'h1000);
      chk("stl_ras", bus.RasEmpty, 1);
      idle();
      tick();
      chk("stl_rel", bus.CurrentPC, 64'h1004);
      chk("stl_ras2", bus.RasEmpty, 1);

`ifdef PC_SEQ_RAS_EN
      jump(64'h200);
      bus.Uncondbranch = 1'b1; bus.Link = 1'b1; bus.SignExtImm = 64'h100;
      settle();
      chk("bl_next", bus.NextPC, 64'h300);
      tick();
      chk("bl_pc", bus.CurrentPC, 64'h300);
      chk("bl_ne", bus.RasEmpty, 0);
      idle();
      bus.Return = 1'b1; bus.RegTarget = 64'hDEAD0;
      settle();
      chk("ret_next", bus.NextPC, 64'h204);
      chk("ret_tk", bus.Taken, 1);
      tick();
      chk("ret_pc", bus.CurrentPC, 64'h204);
      chk("ret_empty", bus.RasEmpty, 1);

      for (int k = 0; k < 5; k++) begin
         idle();
         bus.Uncondbranch = 1'b1; bus.Link = 1'b1; bus.SignExtImm = 64'h100;
         tick();
         chk("nest_pc", bus.CurrentPC, 64'h304 + 64'(k * 256));
         chk("nest_full", bus.RasFull, (k >= 3) ? 64'd1 : 64'd0);
      end
      for (int k = 0; k < 5; k++) begin
         logic [63:0] exp;
         idle();
         bus.Return = 1'b1; bus.RegTarget = 64'h7000;
         if (k == 0) begin
            bus.BranchReg = 1'b1; bus.Uncondbranch = 1'b1; bus.SignExtImm = 64'h40;
         end
         exp = (k < 4) ? 64'h608 - 64'(k * 256) : 64'h7000;
         settle();
         chk("pop_next", bus.NextPC, exp);
         chk("pop_tk", bus.Taken, 1);
         tick();
         chk("pop_pc", bus.CurrentPC, exp);
      end
      chk("pop_empty", bus.RasEmpty, 1);

      // push and pop together replace the top
      idle();
      bus.Uncondbranch = 1'b1; bus.Link = 1'b1; bus.SignExtImm = 64'h100;
      tick();
      chk("sw_bl", bus.CurrentPC, 64'h7100);
      bus.Return = 1'b1; bus.RegTarget = 64'h9000; bus.SignExtImm = 64'h40;
      settle();
      chk("sw_next", bus.NextPC, 64'h7004);
      tick();
      chk("sw_pc", bus.CurrentPC, 64'h7004);
      chk("sw_ne", bus.RasEmpty, 0);
      chk("sw_nf", bus.RasFull, 0);
      idle();
      bus.Return = 1'b1; bus.RegTarget = 64'h9000;
      settle();
      chk("sw_ret", bus.NextPC, 64'h7104);
      tick();
      chk("sw_empty", bus.RasEmpty, 1);

      // reset during a push discards the stack
      idle();
      bus.Uncondbranch = 1'b1; bus.Link = 1'b1; bus.SignExtImm = 64'h100;
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      idle();
      chk("mrst_pc", bus.CurrentPC, 64'h400);
      chk("mrst_empty", bus.RasEmpty, 1);
      bus.Return = 1'b1; bus.RegTarget = 64'h5000;
      settle();
      chk("mrst_ret", bus.NextPC, 64'h5000);
`else
      jump(64'h200);
      bus.Uncondbranch = 1'b1; bus.Link = 1'b1; bus.SignExtImm = 64'h100;
      tick();
      chk("bl_pc", bus.CurrentPC, 64'h300);
      chk("bl_empty", bus.RasEmpty, 1);
      chk("bl_full", bus.RasFull, 0);
      idle();
      bus.Return = 1'b1; bus.BranchReg = 1'b1; bus.Uncondbranch = 1'b1;
      bus.RegTarget = 64'h9000; bus.SignExtImm = 64'h40;
      settle();
      chk("ret_next", bus.NextPC, 64'h9000);
      chk("ret_tk", bus.Taken, 1);
      tick();
      chk("ret_pc", bus.CurrentPC, 64'h9000);
      idle();
      bus.Uncondbranch = 1'b1; bus.SignExtImm = 64'h100;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      idle();
      chk("mrst_pc", bus.CurrentPC, 64'h400);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/next_pc_seq.md
# next_pc_seq

Parametrised program-counter sequencer for the LEGv8 datapath, successor to the combinational next-PC adder. It owns the PC register and resolves the fetch address each cycle from sequential, conditional (CBZ/CBNZ), unconditional, register-indirect and return flows. It includes stall support and an optional return-address stack (RAS). It sits between the control/ALU outputs and instruction-memory address input.

## Interface
- WIDTH, 64, PC and offset width in bits
- RESET_PC, 0, PC value loaded on reset
- INSTR_BYTES, 4, sequential increment; power of two
- RAS_DEPTH, 4, return-address stack entries (≥2); used only with PC_SEQ_RAS_EN

- CLK  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears PC to RESET_PC and empties RAS
- Stall  input  1  hold PC and RAS this cycle
- Branch  input  1  conditional branch instruction
- BranchNZ  input  1  with Branch: 0 = CBZ (taken on zero), 1 = CBNZ (taken on non-zero)
- ALUZero  input  1  ALU zero flag
- Uncondbranch  input  1  B/BL
- Link  input  1  BL: push return address
- BranchReg  input  1  BR: jump to RegTarget
- Return  input  1  RET: pop RAS, or use RegTarget
- SignExtImm  input  WIDTH  sign-extended, pre-shifted byte offset
- RegTarget  input  WIDTH  register-file target for BR/RET
- CurrentPC  output  WIDTH  registered PC, fetch address
- NextPC  output  WIDTH  combinational value CurrentPC loads on next unstalled edge
- Taken  output  1  non-sequential flow selected this cycle
- MisalignErr  output  1  selected target had nonzero low log2(INSTR_BYTES) bits
- RasEmpty  output  1  RAS count == 0
- RasFull  output  1  RAS count == RAS_DEPTH

## Operation
- Target priority, highest first: Return, BranchReg, Uncondbranch, conditional, sequential.
- Conditional taken = Branch & (ALUZero ^ BranchNZ).
- Sequential: CurrentPC + INSTR_BYTES. Relative: CurrentPC + SignExtImm. Indirect: RegTarget. Return: RAS top if !RasEmpty, else RegTarget.
- All additions are modulo 2^WIDTH; wrap-around is silent.
- Taken = 1 for any non-sequential selection, including a Return that falls back to RegTarget.
- Misalignment:
  - MisalignErr = 1 when the selected target has any nonzero low log2(INSTR_BYTES) bits.
  - NextPC has those bits forced to 0.
- RAS push:
  - Occurs on Link & Uncondbranch & !Stall & !Reset.
  - Pushes CurrentPC + INSTR_BYTES.
  - When full, the push overwrites the oldest entry as a circular buffer; count stays RAS_DEPTH.
- RAS pop:
  - Occurs on Return & !RasEmpty & !Stall & !Reset.
  - Count decrements by 1.
- Simultaneous pop and push in one cycle: the target is the old top, the new return address replaces the top slot, and the count is unchanged.
- Link without Uncondbranch is ignored.

## Timing
- Reset (sampled at edge):
  - CurrentPC = RESET_PC; RAS count = 0; RasEmpty = 1; RasFull = 0.
  - Reset dominates Stall and all branch inputs.
- Outputs during reset:
  - NextPC, Taken and MisalignErr remain combinational functions of the current inputs and state.
  - None of them is stored while Reset is high.
- Every unstalled edge: CurrentPC <= NextPC. Latency from branch inputs to CurrentPC is one cycle.
- Stall = 1:
  - CurrentPC and RAS hold.
  - NextPC, Taken and MisalignErr still reflect the inputs.
  - A stalled push or pop is not performed.
- Reset asserted mid-sequence discards all RAS contents; the first post-reset fetch is RESET_PC.
- NextPC, Taken and MisalignErr are purely combinational from the inputs and CurrentPC/RAS; there is no input-to-output register.

## Configuration
- PC_SEQ_RAS_EN defined:
  - RAS of RAS_DEPTH entries is built.
  - Return pops as described above.
  - RasEmpty and RasFull are live.
- PC_SEQ_RAS_EN undefined:
  - No RAS storage; Link is ignored.
  - Return behaves exactly as BranchReg (target = RegTarget).
  - RasEmpty is tied to 1 and RasFull is tied to 0.

## Test plan
- Reset, RESET_PC=0x400: pulse Reset, then 3 idle cycles -> CurrentPC 0x400, 0x404, 0x408, 0x40C; Taken = 0.
- CBZ/CBNZ at PC 0x100, SignExtImm=0x40:
  - Branch=1, BranchNZ=0, ALUZero=1 -> next PC 0x140.
  - Same with ALUZero=0 -> 0x104.
  - BranchNZ=1, ALUZero=0 -> 0x140.
- Negative offset and wrap:
  - PC 0x10, SignExtImm=-0x20 (two's complement) -> PC 0xFFFF_FFFF_FFFF_FFF0.
  - PC 0xFFFF_FFFF_FFFF_FFFC, sequential -> 0x0.
- RAS (macro defined, RAS_DEPTH=4):
  - BL at 0x200 (imm 0x100) -> PC 0x300, RAS top 0x204.
  - RET -> PC 0x204, RasEmpty = 1.
  - Five nested BLs -> RasFull stays 1; five RETs return the four newest addresses, then fall back to RegTarget.
- Stall and priority:
  - Stall=1 with Uncondbranch=1 for 2 cycles -> CurrentPC unchanged, NextPC shows the target, RAS unchanged.
  - Return=1, BranchReg=1, Uncondbranch=1 together -> Return target wins.
- Misalignment: BranchReg with RegTarget=0x1002 -> MisalignErr = 1, next PC 0x1000.
- Reset mid-operation: Reset during a push cycle -> RAS count 0 and PC = RESET_PC next cycle.
